// File: rtl/fetch_decode_queue_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
package fetch_queue_pkg;

    localparam int unsigned FQ_WIDTH   = 8;
    localparam int unsigned FQ_INSTR_W = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Entry layout at the default pipeline widths.
    typedef struct packed {
        logic [FQ_INSTR_W-1:0] instr;
        logic [FQ_WIDTH-1:0]   pcPlus4;
    } fq_entry_t;

    // Occupancy needs one extra bit so that count can reach DEPTH itself.
    function automatic int unsigned count_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_decode_queue_if.sv
// Fetch/decode handshake bundle for the instruction queue.
interface fetch_decode_queue_if
    import fetch_queue_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned DEPTH   = 4
) ();

    logic                        enqValid;
    logic [INSTR_W-1:0]          InstrF;
    logic [WIDTH-1:0]            PCPlus4F;
    logic                        enqReady;
    logic                        flushD;
    logic                        stallD;
    logic                        validD;
    logic [INSTR_W-1:0]          InstrD;
    logic [WIDTH-1:0]            PCPlus4D;
    logic [count_w(DEPTH)-1:0]   count;

    // Pipeline side: drives fetch data and decode control.
    modport master (
        output enqValid, InstrF, PCPlus4F, flushD, stallD,
        input  enqReady, validD, InstrD, PCPlus4D, count
    );

    // Queue side.
    modport slave (
        input  enqValid, InstrF, PCPlus4F, flushD, stallD,
        output enqReady, validD, InstrD, PCPlus4D, count
    );

endinterface

// File: rtl/fetch_decode_queue_storage.sv
// Entry register array: one synchronous write port, one asynchronous read port, no reset.
module fq_storage #(
    parameter int unsigned DW    = 40,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DW-1:0]            rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/fetch_decode_queue.sv
// In-order decoupling queue between fetch and decode; flush discards every held entry.
module fetch_decode_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    fetch_decode_queue_if.slave  bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = count_w(DEPTH);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [WIDTH-1:0]   pcPlus4;
    } entry_t;

    localparam int unsigned EW = $bits(entry_t);

    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic   w_empty;
    logic   w_full;
    logic   w_enq;
    logic   w_deq;
    entry_t w_wdata;
    entry_t w_rdata;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));

    // enqReady comes from registered count only, so a same-cycle dequeue never frees a slot early.
    assign w_enq = bus.enqValid & ~w_full & ~bus.flushD;
    assign w_deq = ~w_empty & ~bus.stallD & ~bus.flushD;

    assign w_wdata.instr   = bus.InstrF;
    assign w_wdata.pcPlus4 = bus.PCPlus4F;

    fq_storage #(
        .DW    (EW),
        .DEPTH (DEPTH)
    ) u_storage (
        .clk   (clk),
        .we    (w_enq),
        .waddr (r_wr_ptr),
        .wdata (w_wdata),
        .raddr (r_rd_ptr),
        .rdata (w_rdata)
    );

    // Pointer and occupancy state; flush outranks any enqueue or dequeue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (bus.flushD) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Stale storage is hidden whenever the queue is empty.
    assign bus.enqReady = ~w_full;
    assign bus.validD   = ~w_empty;
    assign bus.count    = r_count;
    assign bus.InstrD   = w_empty ? INSTR_W'(NOP_INSTR) : w_rdata.instr;
    assign bus.PCPlus4D = w_empty ? '0 : w_rdata.pcPlus4;

endmodule
